// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: program RAM read port, instruction register handshake and redirect.
interface fetch_unit_if #(
  parameter int unsigned ADDR_W = 9
);
  logic [ADDR_W-1:0] pram_addr;
  logic [7:0]        pram_data_0;
  logic [7:0]        pram_data_1;
  logic [7:0]        pram_data_2;
  logic              ir_valid;
  logic              ir_ready;
  logic [7:0]        ir_opcode;
  logic [7:0]        ir_op1;
  logic [7:0]        ir_op2;
  logic [1:0]        ir_len;
  logic [ADDR_W-1:0] ir_pc;
  logic              jmp_valid;
  logic [ADDR_W-1:0] jmp_addr;
  logic              halted;

  // Fetch unit side
  modport master (
    output pram_addr, ir_valid, ir_opcode, ir_op1, ir_op2, ir_len, ir_pc, halted,
    input  pram_data_0, pram_data_1, pram_data_2, ir_ready, jmp_valid, jmp_addr
  );

  // RAM / decode side
  modport slave (
    input  pram_addr, ir_valid, ir_opcode, ir_op1, ir_op2, ir_len, ir_pc, halted,
    output pram_data_0, pram_data_1, pram_data_2, ir_ready, jmp_valid, jmp_addr
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, captures opcode plus operands from program RAM,
// sizes the instruction, and presents it over a valid/ready handshake.
module fetch_unit #(
  parameter int unsigned     ADDR_W   = 9,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  bus
);

  typedef enum logic [1:0] {
    S_ADDR = 2'd0,
    S_CAP  = 2'd1,
    S_HOLD = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              ir_valid;
  logic [7:0]        ir_opcode;
  logic [7:0]        ir_op1;
  logic [7:0]        ir_op2;
  logic [1:0]        ir_len;
  logic [ADDR_W-1:0] ir_pc;
  logic              halted;
  logic              halt_flag;

  logic [1:0]        len_c;
  logic              halt_op_c;
  logic [7:0]        op1_c;
  logic [7:0]        op2_c;

  // Length decode from the opcode byte currently presented by the RAM
  always_comb begin
    len_c     = 2'd1;
    halt_op_c = 1'b0;
    unique case (bus.pram_data_0[7:6])
      2'b00:   len_c = 2'd1;
      2'b01:   len_c = 2'd2;
      2'b10:   len_c = 2'd3;
      default: begin
        len_c     = 2'd1;
        halt_op_c = 1'b1;
      end
    endcase
    op1_c = (len_c >= 2'd2) ? bus.pram_data_1 : 8'h00;
    op2_c = (len_c == 2'd3) ? bus.pram_data_2 : 8'h00;
  end

  // Fetch sequencer; a redirect overrides whatever the current state would do
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_ADDR;
      pc        <= RESET_PC;
      ir_valid  <= 1'b0;
      ir_opcode <= 8'h00;
      ir_op1    <= 8'h00;
      ir_op2    <= 8'h00;
      ir_len    <= 2'd0;
      ir_pc     <= '0;
      halted    <= 1'b0;
      halt_flag <= 1'b0;
    end else if (bus.jmp_valid) begin
      state     <= S_ADDR;
      pc        <= bus.jmp_addr;
      ir_valid  <= 1'b0;
      halted    <= 1'b0;
      halt_flag <= 1'b0;
    end else begin
      unique case (state)
        S_ADDR: state <= S_CAP;
        S_CAP: begin
          ir_opcode <= bus.pram_data_0;
          ir_op1    <= op1_c;
          ir_op2    <= op2_c;
          ir_len    <= len_c;
          ir_pc     <= pc;
          pc        <= pc + ADDR_W'(len_c);
          ir_valid  <= 1'b1;
          halt_flag <= halt_op_c;
          state     <= S_HOLD;
        end
        S_HOLD: begin
          if (bus.ir_ready) begin
            ir_valid <= 1'b0;
            if (halt_flag) begin
              halted <= 1'b1;
              state  <= S_HALT;
            end else begin
              state <= S_ADDR;
            end
          end
        end
        default: state <= S_HALT;
      endcase
    end
  end

  assign bus.pram_addr = pc;
  assign bus.ir_valid  = ir_valid;
  assign bus.ir_opcode = ir_opcode;
  assign bus.ir_op1    = ir_op1;
  assign bus.ir_op2    = ir_op2;
  assign bus.ir_len    = ir_len;
  assign bus.ir_pc     = ir_pc;
  assign bus.halted    = halted;

endmodule
